// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/response bundle for the immediate encoder.
//   Request  side: in_valid, in_ready, value, is_mem_command
//   Response side: out_valid, out_ready, shift_operand, immediate,
//                  encodable, rot_found
// Modports: master = requester/consumer, slave = the encoder itself.
interface imm_encoder_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] value;
    logic              is_mem_command;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       shift_operand;
    logic              immediate;
    logic              encodable;
    logic [3:0]        rot_found;

    modport master (
        output in_valid, value, is_mem_command, out_ready,
        input  in_ready, out_valid, shift_operand, immediate, encodable, rot_found
    );

    modport slave (
        input  in_valid, value, is_mem_command, out_ready,
        output in_ready, out_valid, shift_operand, immediate, encodable, rot_found
    );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: searches for the ARM 12-bit shift_operand that reproduces a
// 32-bit constant.
//   Data-processing mode: finds the smallest rotate_imm such that
//   value == ROR(imm8, 2*rotate_imm), testing one rotation per cycle.
//   Memory mode: checks that value fits the 12-bit unsigned offset field,
//   answering in the cycle after the request is accepted.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - imm_encoder_if slave modport (valid/ready request and response)
module imm_encoder #(
    parameter int DATA_W    = 32,
    parameter int ROT_STEPS = 16,
    parameter int MEM_OFF_W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_encoder_if.slave bus
);
    localparam int ROT_W = $clog2(ROT_STEPS);
    localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(ROT_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   value_q;
    logic [ROT_W-1:0]    rot_cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [ROT_W+7:0]    shift_operand_q;
    logic                immediate_q;
    logic                encodable_q;
    logic [ROT_W-1:0]    rot_found_q;

    logic [2*DATA_W-1:0] cand_wide_s;
    logic [DATA_W-1:0]   cand_s;
    logic                cand_hit_s;
    logic                mem_fit_s;

    // Candidate imm8 for the current rotation and the memory-offset range test.
    always_comb begin
        cand_wide_s = '0;
        cand_s      = '0;
        cand_hit_s  = 1'b0;
        mem_fit_s   = 1'b0;
        // Rotate-left by 2*rot_cnt: the upper half of the doubled word shifted
        // left is exactly the rotated value, so no iteration is needed.
        cand_wide_s = {value_q, value_q} << {rot_cnt_q, 1'b0};
        cand_s      = cand_wide_s[2*DATA_W-1:DATA_W];
        if (cand_s[DATA_W-1:8] == {(DATA_W-8){1'b0}}) begin
            cand_hit_s = 1'b1;
        end else begin
            cand_hit_s = 1'b0;
        end
        if (bus.value[DATA_W-1:MEM_OFF_W] == {(DATA_W-MEM_OFF_W){1'b0}}) begin
            mem_fit_s = 1'b1;
        end else begin
            mem_fit_s = 1'b0;
        end
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            value_q         <= '0;
            rot_cnt_q       <= '0;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            shift_operand_q <= '0;
            immediate_q     <= 1'b0;
            encodable_q     <= 1'b0;
            rot_found_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        value_q    <= bus.value;
                        rot_cnt_q  <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.is_mem_command) begin
                            // Memory offsets are resolved on the accept edge.
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            immediate_q <= 1'b0;
                            rot_found_q <= '0;
                            if (mem_fit_s) begin
                                encodable_q     <= 1'b1;
                                shift_operand_q <= bus.value[MEM_OFF_W-1:0];
                            end else begin
                                encodable_q     <= 1'b0;
                                shift_operand_q <= '0;
                            end
                        end else begin
                            state_q <= ST_SEARCH;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (cand_hit_s) begin
                        // Rotations are tried in increasing order, so the
                        // first hit is the smallest rotate_imm.
                        state_q         <= ST_DONE;
                        out_valid_q     <= 1'b1;
                        shift_operand_q <= {rot_cnt_q, cand_s[7:0]};
                        rot_found_q     <= rot_cnt_q;
                        encodable_q     <= 1'b1;
                        immediate_q     <= 1'b1;
                    end else if (rot_cnt_q == LAST_ROT) begin
                        state_q         <= ST_DONE;
                        out_valid_q     <= 1'b1;
                        shift_operand_q <= '0;
                        rot_found_q     <= LAST_ROT;
                        encodable_q     <= 1'b0;
                        immediate_q     <= 1'b0;
                    end else begin
                        rot_cnt_q <= rot_cnt_q + {{(ROT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.shift_operand = shift_operand_q;
    assign bus.immediate     = immediate_q;
    assign bus.encodable     = encodable_q;
    assign bus.rot_found     = rot_found_q;
endmodule
